// File: rtl/subservient_dbg_bridge.sv
// Byte-stream command decoder driving the subservient SoC Wishbone debug port.
// Opcodes: 'W' addr+data write, 'R' addr read, 'D' debug-mode set; the host gets ACK 0x06 or NAK 0x15.
module subservient_dbg_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic [31:0] i_wb_dbg_rdt,
  input  logic        i_wb_dbg_ack
);

  localparam logic [1:0] S_IDLE = 2'd0, S_ARG = 2'd1, S_BUS = 2'd2, S_RESP = 2'd3;
  localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, OP_D = 8'h44;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  op;
  logic [2:0]  cnt;
  logic [31:0] adr_sh, dat_sh, adr_nx, dat_nx;
  logic [15:0] tmo;
  logic [31:0] resp_q;
  logic [2:0]  resp_n;
  logic        rx_fire, tx_fire, last_arg, op_known;

  // Gated by reset so the host never sees a ready while the bridge is held.
  assign o_rx_ready   = !i_rst && (state == S_IDLE || state == S_ARG);
  assign o_wb_dbg_sel = 4'hf;

  assign rx_fire  = i_rx_valid && o_rx_ready;
  assign tx_fire  = o_tx_valid && i_tx_ready;
  assign op_known = (i_rx_data == OP_W) || (i_rx_data == OP_R) || (i_rx_data == OP_D);
  assign last_arg = (op == OP_D) || (op == OP_R && cnt == 3'd3) || (cnt == 3'd7);
  assign adr_nx   = {i_rx_data, adr_sh[31:8]};
  assign dat_nx   = {i_rx_data, dat_sh[31:8]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      op           <= 8'h00;
      cnt          <= 3'd0;
      adr_sh       <= 32'h0;
      dat_sh       <= 32'h0;
      tmo          <= 16'h0;
      resp_q       <= 32'h0;
      resp_n       <= 3'd0;
      o_tx_data    <= 8'h00;
      o_tx_valid   <= 1'b0;
      o_debug_mode <= 1'b0;
      o_wb_dbg_adr <= 32'h0;
      o_wb_dbg_dat <= 32'h0;
      o_wb_dbg_we  <= 1'b0;
      o_wb_dbg_stb <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (rx_fire) begin
          if (op_known) begin
            op    <= i_rx_data;
            cnt   <= 3'd0;
            state <= S_ARG;
          end else begin
            o_tx_data  <= NAK;
            o_tx_valid <= 1'b1;
            resp_n     <= 3'd0;
            state      <= S_RESP;
          end
        end
        S_ARG: if (rx_fire) begin
          cnt <= cnt + 3'd1;
          // Bytes 0..3 shift into the address, 4..7 into the data (LSB first).
          if (cnt[2]) dat_sh <= dat_nx;
          else        adr_sh <= adr_nx;
          if (last_arg) begin
            if (op == OP_D || !o_debug_mode) begin
              if (op == OP_D) o_debug_mode <= i_rx_data[0];
              o_tx_data  <= (op == OP_D) ? ACK : NAK;
              o_tx_valid <= 1'b1;
              resp_n     <= 3'd0;
              state      <= S_RESP;
            end else begin
              o_wb_dbg_stb <= 1'b1;
              o_wb_dbg_we  <= (op == OP_W);
              o_wb_dbg_adr <= (op == OP_R) ? adr_nx : adr_sh;
              if (op == OP_W) o_wb_dbg_dat <= dat_nx;
              tmo          <= 16'h0;
              state        <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (i_wb_dbg_ack) begin
            o_wb_dbg_stb <= 1'b0;
            o_tx_valid   <= 1'b1;
            state        <= S_RESP;
            if (o_wb_dbg_we) begin
              o_tx_data <= ACK;
              resp_n    <= 3'd0;
            end else begin
              o_tx_data <= i_wb_dbg_rdt[7:0];
              resp_q    <= {ACK, i_wb_dbg_rdt[31:8]};
              resp_n    <= 3'd4;
            end
          end else if (tmo == TMO_LAST) begin
            o_wb_dbg_stb <= 1'b0;
            o_tx_data    <= NAK;
            o_tx_valid   <= 1'b1;
            resp_n       <= 3'd0;
            state        <= S_RESP;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        default: if (tx_fire) begin
          if (resp_n == 3'd0) begin
            o_tx_valid <= 1'b0;
            state      <= S_IDLE;
          end else begin
            o_tx_data <= resp_q[7:0];
            resp_q    <= {8'h00, resp_q[31:8]};
            resp_n    <= resp_n - 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_dbg_bridge.sv
// Directed bench for subservient_dbg_bridge: command decode, bus cycles, timeout, backpressure, reset.
module tb_subservient_dbg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        debug_mode;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb;
  logic [31:0] wb_rdt = 32'h0;
  logic        wb_ack;

  int checks = 0;
  int passed = 0;
  int stb_total = 0;
  int adr_glitch = 0;
  int wcnt = 0;
  int wait_states = 0;
  bit ack_en = 1'b1;
  logic        stb_prev = 1'b0;
  logic [31:0] adr_prev = 32'h0, dat_prev = 32'h0;
  logic        we_prev = 1'b0;

  always #5 clk = ~clk;

  subservient_dbg_bridge #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_debug_mode(debug_mode),
    .o_wb_dbg_adr(wb_adr), .o_wb_dbg_dat(wb_dat), .o_wb_dbg_sel(wb_sel),
    .o_wb_dbg_we(wb_we), .o_wb_dbg_stb(wb_stb),
    .i_wb_dbg_rdt(wb_rdt), .i_wb_dbg_ack(wb_ack)
  );

  // Responder acks after wait_states idle strobe cycles.
  assign wb_ack = ack_en && wb_stb && (wcnt == wait_states);
  always @(posedge clk) wcnt <= wb_stb ? wcnt + 1 : 0;

  // Strobe cycle counter and address/data/we stability monitor.
  always @(negedge clk) begin
    if (wb_stb) stb_total <= stb_total + 1;
    if (wb_stb && stb_prev && (wb_adr !== adr_prev || wb_dat !== dat_prev || wb_we !== we_prev))
      adr_glitch <= adr_glitch + 1;
    stb_prev <= wb_stb;
    adr_prev <= wb_adr;
    dat_prev <= wb_dat;
    we_prev  <= wb_we;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      $display("FAIL send_timeout byte=%02h never accepted", b);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Receives n bytes (first byte in exp[7:0]); bp randomizes tx_ready and checks stall stability.
  task automatic expect_resp(input string name, input int n, input logic [39:0] exp, input bit bp);
    logic [7:0] b, held;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit got = 0, stalled = 0;
      held = 8'h00;
      b = 8'h00;
      while (!got && t < 200) begin
        @(negedge clk);
        if (tx_valid) begin
          if (stalled) begin
            checks++;
            if (tx_data !== held) $display("FAIL %s_stall byte%0d got=%02h held=%02h", name, i, tx_data, held);
            else passed++;
          end
          tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          if (tx_ready) begin
            b = tx_data;
            got = 1;
          end else begin
            stalled = 1;
            held = tx_data;
          end
        end
        t++;
      end
      checks++;
      if (!got) begin
        $display("FAIL %s_timeout byte%0d no tx_valid", name, i);
      end else begin
        @(posedge clk);
        #1 tx_ready = 1'b0;
        if (b !== exp[8*i +: 8]) $display("FAIL %s byte%0d got=%02h exp=%02h", name, i, b, exp[8*i +: 8]);
        else passed++;
      end
    end
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1)
      $display("FAIL %s_end tx_valid=%b rx_ready=%b exp 0/1", name, tx_valid, rx_ready);
    else passed++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (rx_ready !== 1'b0 || wb_stb !== 1'b0 || tx_valid !== 1'b0 || debug_mode !== 1'b0 ||
        wb_adr !== 32'h0 || wb_dat !== 32'h0 || wb_we !== 1'b0 || wb_sel !== 4'hf || tx_data !== 8'h00)
      $display("FAIL reset_vals rdy=%b stb=%b txv=%b dbg=%b adr=%h dat=%h we=%b sel=%h txd=%h",
               rx_ready, wb_stb, tx_valid, debug_mode, wb_adr, wb_dat, wb_we, wb_sel, tx_data);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b1 || debug_mode !== 1'b0)
      $display("FAIL reset_release rx_ready=%b debug=%b exp 1/0", rx_ready, debug_mode);
    else passed++;
  endtask

  task automatic test_write_dbg_off();
    int s0 = stb_total;
    logic [7:0] v[9] = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (v[i]) send_byte(v[i]);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h15) $display("FAIL wr_off_lat txv=%b txd=%02h exp 1/15", tx_valid, tx_data);
    else passed++;
    expect_resp("wr_off", 1, 40'h15, 0);
    checks++;
    if (stb_total != s0) $display("FAIL wr_off_stb got=%0d cycles exp=0", stb_total - s0);
    else passed++;
  endtask

  task automatic test_bad_opcode();
    send_byte(8'hAA);
    expect_resp("bad_op", 1, 40'h15, 0);
  endtask

  task automatic test_write();
    int s0;
    logic [7:0] v[9] = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_byte(8'h44);
    send_byte(8'h01);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h06 || debug_mode !== 1'b1)
      $display("FAIL dbg_on txv=%b txd=%02h dbg=%b exp 1/06/1", tx_valid, tx_data, debug_mode);
    else passed++;
    expect_resp("dbg_on", 1, 40'h06, 0);
    wait_states = 1;
    s0 = stb_total;
    foreach (v[i]) send_byte(v[i]);
    checks++;
    if (wb_stb !== 1'b1 || wb_adr !== 32'h00001000 || wb_dat !== 32'hDEADBEEF || wb_we !== 1'b1 || wb_sel !== 4'hf)
      $display("FAIL wr_bus stb=%b adr=%h dat=%h we=%b sel=%h exp 1/00001000/deadbeef/1/f",
               wb_stb, wb_adr, wb_dat, wb_we, wb_sel);
    else passed++;
    expect_resp("wr", 1, 40'h06, 0);
    checks++;
    if (stb_total - s0 != 2) $display("FAIL wr_stb_len got=%0d exp=2", stb_total - s0);
    else passed++;
  endtask

  task automatic test_read(input string name, input logic [31:0] rdt, input logic [39:0] exp, input bit bp);
    int s0 = stb_total;
    wait_states = 3;
    wb_rdt = rdt;
    send_byte(8'h52);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (wb_stb !== 1'b1 || wb_we !== 1'b0 || wb_adr !== 32'h4)
      $display("FAIL %s_bus stb=%b we=%b adr=%h exp 1/0/4", name, wb_stb, wb_we, wb_adr);
    else passed++;
    expect_resp(name, 5, exp, bp);
    checks++;
    if (stb_total - s0 != 4) $display("FAIL %s_stb_len got=%0d exp=4", name, stb_total - s0);
    else passed++;
  endtask

  task automatic test_timeout();
    int s0 = stb_total;
    ack_en = 1'b0;
    send_byte(8'h52);
    repeat (4) send_byte(8'h08);
    expect_resp("tmo", 1, 40'h15, 0);
    checks++;
    if (stb_total - s0 != 8) $display("FAIL tmo_stb_len got=%0d exp=8", stb_total - s0);
    else passed++;
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int s0;
    logic [7:0] v[9] = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    ack_en = 1'b0;
    send_byte(8'h52);
    repeat (4) send_byte(8'h00);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (wb_stb !== 1'b0 || debug_mode !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b0)
      $display("FAIL rst_mid stb=%b dbg=%b txv=%b rdy=%b exp 0/0/0/0", wb_stb, debug_mode, tx_valid, rx_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    wait_states = 0;
    send_byte(8'h44);
    send_byte(8'h01);
    expect_resp("rst_dbg", 1, 40'h06, 0);
    s0 = stb_total;
    foreach (v[i]) send_byte(v[i]);
    checks++;
    if (wb_adr !== 32'h20 || wb_dat !== 32'h11223344 || wb_we !== 1'b1)
      $display("FAIL rst_wr_bus adr=%h dat=%h we=%b exp 20/11223344/1", wb_adr, wb_dat, wb_we);
    else passed++;
    expect_resp("rst_wr", 1, 40'h06, 0);
    checks++;
    if (stb_total - s0 != 1) $display("FAIL rst_wr_stb_len got=%0d exp=1", stb_total - s0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_dbg_off();
    test_bad_opcode();
    test_write();
    test_read("rd", 32'h12345678, 40'h06_12345678, 0);
    test_read("rd_bp", 32'hA1B2C3D4, 40'h06_A1B2C3D4, 1);
    test_timeout();
    test_reset_mid();
    checks++;
    if (adr_glitch != 0) $display("FAIL bus_stable changes=%0d exp=0", adr_glitch);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

endmodule
